spi_burst_ctrl: RTL
===================

Name: spi_burst_ctrl

Overview:
- Parametrised SPI-command burst controller between the MCU SPI slave front-end and the RAW/SPIKE sample FIFOs.
- Decodes header words arriving on the SPI receive stream and, when enough data is buffered, starts a RAW or SPIKE burst.
- Counts the words read out during the burst, closes the burst on length and sender handshake, and reports completion, timeout and abort.
- Supports two independent modes with per-mode headers, lengths and FIFO thresholds, an abort command and a stall watchdog.

Parameters:
- DW, 16, SPI word width.
- LW, 10, burst length / counter width.
- CW, 13, FIFO level width.
- RAW_HEADER, 16'hC691, header that requests a RAW burst.
- SPIKE_HEADER, 16'h1999, header that requests a SPIKE burst.
- ABORT_HEADER, 16'hA5A5, header that aborts an active burst.
- RAW_MIN_LEVEL, 700, minimum raw FIFO level needed to accept RAW.
- SPIKE_MIN_LEVEL, 1, minimum spike FIFO level needed to accept SPIKE.
- TIMEOUT, 65535, idle cycles allowed in a burst with no read; 0 disables the watchdog.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- spi_data_in  in  DW  received SPI word.
- data_in_valid  in  1  spi_data_in valid for one cycle.
- raw_length  in  LW  RAW burst length in words.
- spike_length  in  LW  SPIKE burst length in words.
- raw_level  in  CW  raw FIFO fill level.
- spike_level  in  CW  spike FIFO fill level.
- rd_en_raw  in  1  raw FIFO read strobe.
- rd_en_spike  in  1  spike FIFO read strobe.
- send_finish  in  1  SPI sender idle/word-complete flag.
- STATE  out  2  current state encoding.
- start_raw  out  1  one-cycle RAW start pulse.
- start_spike  out  1  one-cycle SPIKE start pulse.
- busy_raw  out  1  high while in S_RAW.
- busy_spike  out  1  high while in S_SPIKE.
- length_cnt  out  LW  words read in the current burst.
- done_pulse  out  1  one-cycle pulse on entering S_FINISH.
- timeout_err  out  1  sticky flag: the watchdog fired.
- rejected  out  1  one-cycle pulse: header matched but FIFO level was below threshold.
- frame_cnt  out  16  count of bursts completed without timeout; wraps.

Behaviour:
- All outputs are registered.
- Reset values: STATE=S_IDLE, every output 0.
- States: S_IDLE=0, S_RAW=1, S_SPIKE=2, S_FINISH=3.
- S_IDLE:
  - A word "matches" when data_in_valid=1 and spi_data_in equals a header.
  - RAW_HEADER match and raw_level>=RAW_MIN_LEVEL: go to S_RAW next cycle; start_raw=1 in that first S_RAW cycle only.
  - SPIKE_HEADER match and spike_level>=SPIKE_MIN_LEVEL: same, into S_SPIKE with start_spike.
  - Header match with level below threshold: stay in S_IDLE; rejected=1 the next cycle.
  - RAW_HEADER==SPIKE_HEADER: RAW wins.
  - Accepting a burst clears timeout_err and loads length_cnt=0.
- S_RAW / S_SPIKE:
  - Only the active mode's rd_en increments length_cnt; the other strobe is ignored.
  - length_cnt saturates at 2^LW-1.
  - Go to S_FINISH when length_cnt>=active length and send_finish=1 in the same cycle.
  - length=0 finishes on the first cycle send_finish=1.
- Watchdog:
  - Counts consecutive cycles in S_RAW/S_SPIKE with no active rd_en; resets on each active rd_en and on state entry.
  - On reaching TIMEOUT: go to S_FINISH, timeout_err=1.
  - Watchdog beats the length condition if both occur in the same cycle.
- ABORT_HEADER match in S_RAW/S_SPIKE: go directly to S_IDLE, length_cnt=0. No done_pulse, no frame_cnt change.
- Any other header while in S_RAW, S_SPIKE or S_FINISH is ignored.
- S_FINISH:
  - done_pulse=1 on the entry cycle.
  - frame_cnt increments at entry unless the entry was caused by timeout.
  - length_cnt is held for readout, then cleared when leaving for S_IDLE.
  - Return to S_IDLE when send_finish=1. If send_finish is already 1 at entry, leave on the next cycle, so S_FINISH lasts at least one cycle.
- Asserting rst_n low mid-burst returns immediately to reset values. Sticky flags and frame_cnt are lost.

Test Plan:
- raw_level=700, raw_length=4, C691 with valid -> start_raw pulses once, busy_raw=1; 4 rd_en_raw then send_finish -> done_pulse, length_cnt=4, frame_cnt=1, back to S_IDLE.
- raw_level=699, C691 -> rejected pulses, STATE stays 0, no start_raw.
- spike_length=3, 1999 accepted; toggle rd_en_raw 5 times and rd_en_spike 3 times -> length_cnt=3 and finishes; the raw strobes are ignored.
- TIMEOUT=8, RAW accepted, no reads -> after 8 cycles S_FINISH, timeout_err=1, frame_cnt unchanged; next accepted header clears timeout_err.
- RAW active with length_cnt=2, A5A5 arrives -> S_IDLE next cycle, length_cnt=0, no done_pulse.
- raw_length=0, send_finish held 1 -> S_RAW one cycle, S_FINISH one cycle, S_IDLE. rst_n pulsed low mid-burst -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/spi_burst_ctrl.sv
// SPI-command burst controller: decodes RAW/SPIKE/ABORT headers, gates bursts on
// FIFO level, counts read-out words, and closes bursts on length, handshake or watchdog.
module spi_burst_ctrl #(
    parameter int unsigned    DW              = 16,
    parameter int unsigned    LW              = 10,
    parameter int unsigned    CW              = 13,
    parameter logic [DW-1:0]  RAW_HEADER      = 16'hC691,
    parameter logic [DW-1:0]  SPIKE_HEADER    = 16'h1999,
    parameter logic [DW-1:0]  ABORT_HEADER    = 16'hA5A5,
    parameter int unsigned    RAW_MIN_LEVEL   = 700,
    parameter int unsigned    SPIKE_MIN_LEVEL = 1,
    parameter int unsigned    TIMEOUT         = 65535
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] spi_data_in,
    input  logic          data_in_valid,
    input  logic [LW-1:0] raw_length,
    input  logic [LW-1:0] spike_length,
    input  logic [CW-1:0] raw_level,
    input  logic [CW-1:0] spike_level,
    input  logic          rd_en_raw,
    input  logic          rd_en_spike,
    input  logic          send_finish,
    output logic [1:0]    STATE,
    output logic          start_raw,
    output logic          start_spike,
    output logic          busy_raw,
    output logic          busy_spike,
    output logic [LW-1:0] length_cnt,
    output logic          done_pulse,
    output logic          timeout_err,
    output logic          rejected,
    output logic [15:0]   frame_cnt
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RAW    = 2'd1,
        S_SPIKE  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    localparam int unsigned   WDW     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [LW-1:0] CNT_MAX = '1;

    state_t         state_q, state_d;
    logic [LW-1:0]  cnt_q, cnt_d;
    logic [WDW-1:0] wd_q, wd_d;
    logic           terr_q, terr_d;
    logic [15:0]    frame_q, frame_d;
    logic           start_raw_q, start_raw_d;
    logic           start_spike_q, start_spike_d;
    logic           busy_raw_q, busy_raw_d;
    logic           busy_spike_q, busy_spike_d;
    logic           done_q, done_d;
    logic           rej_q, rej_d;

    logic           raw_hit, spike_hit, abort_hit;
    logic           raw_ok, spike_ok;
    logic           active_rd, wd_fire;
    logic [LW-1:0]  active_len;

    // RAW takes priority when both headers are configured to the same word.
    assign raw_hit    = data_in_valid && (spi_data_in == RAW_HEADER);
    assign spike_hit  = data_in_valid && (spi_data_in == SPIKE_HEADER) && !raw_hit;
    assign abort_hit  = data_in_valid && (spi_data_in == ABORT_HEADER);
    assign raw_ok     = int'(raw_level) >= int'(RAW_MIN_LEVEL);
    assign spike_ok   = int'(spike_level) >= int'(SPIKE_MIN_LEVEL);
    assign active_rd  = (state_q == S_RAW) ? rd_en_raw : rd_en_spike;
    assign active_len = (state_q == S_RAW) ? raw_length : spike_length;
    // Fires on the TIMEOUT-th consecutive idle burst cycle; TIMEOUT=0 disables it.
    assign wd_fire    = (TIMEOUT != 0) && !active_rd && (int'(wd_q) == int'(TIMEOUT) - 1);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        wd_d          = wd_q;
        terr_d        = terr_q;
        frame_d       = frame_q;
        start_raw_d   = 1'b0;
        start_spike_d = 1'b0;
        done_d        = 1'b0;
        rej_d         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (raw_hit) begin
                    if (raw_ok) begin
                        state_d     = S_RAW;
                        start_raw_d = 1'b1;
                        cnt_d       = '0;
                        wd_d        = '0;
                        terr_d      = 1'b0;
                    end else begin
                        rej_d = 1'b1;
                    end
                end else if (spike_hit) begin
                    if (spike_ok) begin
                        state_d       = S_SPIKE;
                        start_spike_d = 1'b1;
                        cnt_d         = '0;
                        wd_d          = '0;
                        terr_d        = 1'b0;
                    end else begin
                        rej_d = 1'b1;
                    end
                end
            end
            S_RAW, S_SPIKE: begin
                if (abort_hit) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    wd_d    = '0;
                end else begin
                    if (active_rd && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
                    wd_d = active_rd ? '0 : wd_q + 1'b1;
                    // Watchdog is checked first so it wins over a same-cycle length close.
                    if (wd_fire) begin
                        state_d = S_FINISH;
                        terr_d  = 1'b1;
                        done_d  = 1'b1;
                        wd_d    = '0;
                    end else if ((cnt_q >= active_len) && send_finish) begin
                        state_d = S_FINISH;
                        done_d  = 1'b1;
                        frame_d = frame_q + 16'd1;
                        wd_d    = '0;
                    end
                end
            end
            S_FINISH: begin
                if (send_finish) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_raw_d   = (state_d == S_RAW);
        busy_spike_d = (state_d == S_SPIKE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            wd_q          <= '0;
            terr_q        <= 1'b0;
            frame_q       <= '0;
            start_raw_q   <= 1'b0;
            start_spike_q <= 1'b0;
            busy_raw_q    <= 1'b0;
            busy_spike_q  <= 1'b0;
            done_q        <= 1'b0;
            rej_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            wd_q          <= wd_d;
            terr_q        <= terr_d;
            frame_q       <= frame_d;
            start_raw_q   <= start_raw_d;
            start_spike_q <= start_spike_d;
            busy_raw_q    <= busy_raw_d;
            busy_spike_q  <= busy_spike_d;
            done_q        <= done_d;
            rej_q         <= rej_d;
        end
    end

    assign STATE       = state_q;
    assign start_raw   = start_raw_q;
    assign start_spike = start_spike_q;
    assign busy_raw    = busy_raw_q;
    assign busy_spike  = busy_spike_q;
    assign length_cnt  = cnt_q;
    assign done_pulse  = done_q;
    assign timeout_err = terr_q;
    assign rejected    = rej_q;
    assign frame_cnt   = frame_q;

endmodule
